// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared types and defaults for the reset sequencer.
//   rst_seq_state_t     - sequencer state encoding
//   DEF_*_CYCLES        - default stretch / debounce / timeout lengths
//   CUR_STAGE_W         - width of the cur_stage_o stage index
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_WAIT_ACK,
    ST_DONE,
    ST_ERROR
  } rst_seq_state_t;

  localparam int DEF_STRETCH_CYCLES  = 16;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_TIMEOUT_CYCLES  = 256;
  localparam int CUR_STAGE_W         = 4;

endpackage

// File: rtl/rst_debounce.sv
// rst_debounce: two-flop synchronizer followed by a consecutive-high counter.
// level goes high once DEBOUNCE_CYCLES consecutive synchronized high samples
// have been seen and stays high until the first synchronized low sample.
//   sys_clock_0 - clock
//   reset_0     - synchronous active-high reset (clears sync flops and count)
//   async_in    - asynchronous raw request
//   level       - qualified request level
module rst_debounce
  import rst_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic sys_clock_0,
  input  logic reset_0,
  input  logic async_in,
  output logic level
);

  logic       sync_q1;
  logic       sync_q2;
  logic [7:0] high_cnt;

  always_ff @(posedge sys_clock_0) begin
    if (reset_0) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      high_cnt <= '0;
    end else begin
      sync_q1 <= async_in;
      sync_q2 <= sync_q1;
      if (!sync_q2)
        high_cnt <= '0;
      else if (high_cnt != 8'(DEBOUNCE_CYCLES))
        high_cnt <= high_cnt + 8'd1;   // saturate at the qualify threshold
    end
  end

  assign level = (high_cnt == 8'(DEBOUNCE_CYCLES));

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_STAGES reset outputs one at a time, each
// waiting for its stage acknowledge before the next is released.
// Optional feature macro: RST_SEQ_TIMEOUT_EN enables the per-stage
// acknowledge timeout and the ERROR state; otherwise seq_error_o is 0.
//   sys_clock_0  - clock
//   reset_0      - synchronous active-high master reset
//   ext_rst_req  - asynchronous reset button request (debounced internally)
//   stage_ack_i  - per-stage ready acknowledges
//   stage_rst_o  - per-stage active-high resets
//   seq_done_o   - all stages released and acknowledged
//   seq_error_o  - acknowledge timeout occurred
//   cur_stage_o  - stage being released; NUM_STAGES when done
//
// state    | meaning
// ---------+-----------------------------------------------------------
// HOLD     | all stages in reset, stretch counter running
// RELEASE  | drop reset of stage cur_stage_o on this edge
// WAIT_ACK | wait for stage_ack_i[cur_stage_o] (optionally with timeout)
// DONE     | all stages out of reset, seq_done_o high
// ERROR    | ack timeout; all stages back in reset, seq_error_o high
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES      = 3,
  parameter int STRETCH_CYCLES  = DEF_STRETCH_CYCLES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic                   sys_clock_0,
  input  logic                   reset_0,
  input  logic                   ext_rst_req,
  input  logic [NUM_STAGES-1:0]  stage_ack_i,
  output logic [NUM_STAGES-1:0]  stage_rst_o,
  output logic                   seq_done_o,
  output logic                   seq_error_o,
  output logic [CUR_STAGE_W-1:0] cur_stage_o
);

  rst_seq_state_t        state;
  logic [15:0]           stretch_cnt;
  logic                  req_db;
  logic [NUM_STAGES-1:0] cur_mask;
  logic                  ack_cur;
  logic                  last_stage;

  rst_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .sys_clock_0(sys_clock_0),
    .reset_0    (reset_0),
    .async_in   (ext_rst_req),
    .level      (req_db)
  );

  // One-hot select of the current stage; avoids indexing with a 4-bit
  // index into a possibly narrower vector.
  always_comb begin
    cur_mask = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      if (cur_stage_o == CUR_STAGE_W'(i))
        cur_mask[i] = 1'b1;
  end

  assign ack_cur    = |(stage_ack_i & cur_mask);
  assign last_stage = (cur_stage_o == CUR_STAGE_W'(NUM_STAGES - 1));

`ifdef RST_SEQ_TIMEOUT_EN
  logic [15:0] to_cnt;
`else
  assign seq_error_o = 1'b0;
`endif

  always_ff @(posedge sys_clock_0) begin
    // reset_0 and a debounced request have the same effect, and both
    // override any acknowledge arriving on the same edge.
    if (reset_0 || req_db) begin
      state       <= ST_HOLD;
      stage_rst_o <= '1;
      seq_done_o  <= 1'b0;
      cur_stage_o <= '0;
      stretch_cnt <= '0;
`ifdef RST_SEQ_TIMEOUT_EN
      to_cnt      <= '0;
      seq_error_o <= 1'b0;
`endif
    end else begin
      case (state)
        ST_HOLD: begin
          stage_rst_o <= '1;
          if (stretch_cnt == 16'(STRETCH_CYCLES)) begin
            state       <= ST_RELEASE;
            cur_stage_o <= '0;
            stretch_cnt <= '0;
          end else begin
            stretch_cnt <= stretch_cnt + 16'd1;
          end
        end
        ST_RELEASE: begin
          stage_rst_o <= stage_rst_o & ~cur_mask;
          state       <= ST_WAIT_ACK;
`ifdef RST_SEQ_TIMEOUT_EN
          to_cnt      <= '0;
`endif
        end
        ST_WAIT_ACK: begin
          if (ack_cur) begin
            cur_stage_o <= cur_stage_o + CUR_STAGE_W'(1);
            state       <= last_stage ? ST_DONE : ST_RELEASE;
          end
`ifdef RST_SEQ_TIMEOUT_EN
          else if (to_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            state       <= ST_ERROR;
            stage_rst_o <= '1;
            seq_error_o <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end
        ST_DONE: begin
          seq_done_o  <= 1'b1;
          stage_rst_o <= '0;
        end
`ifdef RST_SEQ_TIMEOUT_EN
        ST_ERROR: begin
          seq_error_o <= 1'b1;
          stage_rst_o <= '1;
        end
`endif
        default: begin
          state       <= ST_HOLD;
          stage_rst_o <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_0;
  logic       ext_rst_req;
  logic [2:0] stage_ack_i;
  logic [2:0] stage_rst_o;
  logic       seq_done_o;
  logic       seq_error_o;
  logic [3:0] cur_stage_o;

  int checks = 0;
  int errors = 0;

  reset_sequencer dut (
    .sys_clock_0(clk),
    .reset_0    (reset_0),
    .ext_rst_req(ext_rst_req),
    .stage_ack_i(stage_ack_i),
    .stage_rst_o(stage_rst_o),
    .seq_done_o (seq_done_o),
    .seq_error_o(seq_error_o),
    .cur_stage_o(cur_stage_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset_0 = 1'b1; ext_rst_req = 1'b0; stage_ack_i = 3'b000;
    step(3);
    checks++; if (stage_rst_o !== 3'b111) begin errors++; $display("FAIL reset_rst: got %b expected 111", stage_rst_o); end
    checks++; if (seq_done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", seq_done_o); end
    checks++; if (seq_error_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", seq_error_o); end
    checks++; if (cur_stage_o !== 4'd0) begin errors++; $display("FAIL reset_cur: got %0d expected 0", cur_stage_o); end
  endtask

  task automatic test_sequence();
    reset_0 = 1'b1; stage_ack_i = 3'b000;
    step(2);
    reset_0 = 1'b0;
    step(17);
    checks++; if (stage_rst_o !== 3'b111) begin errors++; $display("FAIL seq_before_first: got %b expected 111", stage_rst_o); end
    step();
    checks++; if (stage_rst_o !== 3'b110) begin errors++; $display("FAIL seq_first_release: got %b expected 110", stage_rst_o); end
    stage_ack_i = 3'b110;
    step(2);
    checks++; if (cur_stage_o !== 4'd0) begin errors++; $display("FAIL seq_wrong_ack_ignored: got %0d expected 0", cur_stage_o); end
    stage_ack_i = 3'b001;
    step();
    checks++; if (cur_stage_o !== 4'd1) begin errors++; $display("FAIL seq_cur1: got %0d expected 1", cur_stage_o); end
    checks++; if (stage_rst_o !== 3'b110) begin errors++; $display("FAIL seq_rst_hold0: got %b expected 110", stage_rst_o); end
    stage_ack_i = 3'b000;
    step();
    checks++; if (stage_rst_o !== 3'b100) begin errors++; $display("FAIL seq_second_release: got %b expected 100", stage_rst_o); end
    step(2);
    stage_ack_i = 3'b010;
    step();
    checks++; if (cur_stage_o !== 4'd2) begin errors++; $display("FAIL seq_cur2: got %0d expected 2", cur_stage_o); end
    stage_ack_i = 3'b000;
    step();
    checks++; if (stage_rst_o !== 3'b000) begin errors++; $display("FAIL seq_third_release: got %b expected 000", stage_rst_o); end
    step(2);
    stage_ack_i = 3'b100;
    step();
    checks++; if (cur_stage_o !== 4'd3) begin errors++; $display("FAIL seq_cur3: got %0d expected 3", cur_stage_o); end
    checks++; if (seq_done_o !== 1'b0) begin errors++; $display("FAIL seq_done_early: got %b expected 0", seq_done_o); end
    step();
    checks++; if (seq_done_o !== 1'b1) begin errors++; $display("FAIL seq_done: got %b expected 1", seq_done_o); end
    checks++; if (stage_rst_o !== 3'b000) begin errors++; $display("FAIL seq_done_rst: got %b expected 000", stage_rst_o); end
  endtask

  task automatic test_all_acks();
    reset_0 = 1'b1; stage_ack_i = 3'b111;
    step(2);
    reset_0 = 1'b0;
    step(18);
    checks++; if (stage_rst_o !== 3'b110) begin errors++; $display("FAIL acks_rel0: got %b expected 110", stage_rst_o); end
    step(2);
    checks++; if (stage_rst_o !== 3'b100) begin errors++; $display("FAIL acks_rel1: got %b expected 100", stage_rst_o); end
    step(2);
    checks++; if (stage_rst_o !== 3'b000) begin errors++; $display("FAIL acks_rel2: got %b expected 000", stage_rst_o); end
    step();
    checks++; if (seq_done_o !== 1'b0) begin errors++; $display("FAIL acks_done_early: got %b expected 0", seq_done_o); end
    step();
    checks++; if (seq_done_o !== 1'b1) begin errors++; $display("FAIL acks_done: got %b expected 1", seq_done_o); end
  endtask

  task automatic test_debounce();
    ext_rst_req = 1'b1;
    step(3);
    ext_rst_req = 1'b0;
    step(8);
    checks++; if (seq_done_o !== 1'b1) begin errors++; $display("FAIL db_short_done: got %b expected 1", seq_done_o); end
    checks++; if (stage_rst_o !== 3'b000) begin errors++; $display("FAIL db_short_rst: got %b expected 000", stage_rst_o); end
    ext_rst_req = 1'b1;
    step(6);
    ext_rst_req = 1'b0;
    checks++; if (stage_rst_o !== 3'b000) begin errors++; $display("FAIL db_not_yet: got %b expected 000", stage_rst_o); end
    step();
    checks++; if (stage_rst_o !== 3'b111) begin errors++; $display("FAIL db_rst_set: got %b expected 111", stage_rst_o); end
    checks++; if (seq_done_o !== 1'b0) begin errors++; $display("FAIL db_done_clr: got %b expected 0", seq_done_o); end
    checks++; if (cur_stage_o !== 4'd0) begin errors++; $display("FAIL db_cur: got %0d expected 0", cur_stage_o); end
    step(19);
    checks++; if (stage_rst_o !== 3'b111) begin errors++; $display("FAIL db_stretch: got %b expected 111", stage_rst_o); end
    step();
    checks++; if (stage_rst_o !== 3'b110) begin errors++; $display("FAIL db_replay: got %b expected 110", stage_rst_o); end
  endtask

  task automatic test_reset_mid();
    reset_0 = 1'b1; stage_ack_i = 3'b000;
    step();
    reset_0 = 1'b0;
    step(18);
    stage_ack_i = 3'b001;
    step();
    stage_ack_i = 3'b000;
    step();
    checks++; if (stage_rst_o !== 3'b100) begin errors++; $display("FAIL mid_stage1: got %b expected 100", stage_rst_o); end
    step(2);
    reset_0 = 1'b1;
    step();
    reset_0 = 1'b0;
    checks++; if (stage_rst_o !== 3'b111) begin errors++; $display("FAIL mid_abort: got %b expected 111", stage_rst_o); end
    checks++; if (cur_stage_o !== 4'd0) begin errors++; $display("FAIL mid_cur: got %0d expected 0", cur_stage_o); end
    step(17);
    checks++; if (stage_rst_o !== 3'b111) begin errors++; $display("FAIL mid_stretch: got %b expected 111", stage_rst_o); end
    step();
    checks++; if (stage_rst_o !== 3'b110) begin errors++; $display("FAIL mid_restart: got %b expected 110", stage_rst_o); end
  endtask

  task automatic test_timeout();
    reset_0 = 1'b1; stage_ack_i = 3'b000;
    step();
    reset_0 = 1'b0;
    step(18);
    stage_ack_i = 3'b001;
    step();
    stage_ack_i = 3'b000;
    step();
    checks++; if (stage_rst_o !== 3'b100) begin errors++; $display("FAIL to_stage1: got %b expected 100", stage_rst_o); end
`ifdef RST_SEQ_TIMEOUT_EN
    step(255);
    checks++; if (seq_error_o !== 1'b0) begin errors++; $display("FAIL to_err_early: got %b expected 0", seq_error_o); end
    step();
    checks++; if (seq_error_o !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", seq_error_o); end
    checks++; if (stage_rst_o !== 3'b111) begin errors++; $display("FAIL to_rst: got %b expected 111", stage_rst_o); end
    checks++; if (cur_stage_o !== 4'd1) begin errors++; $display("FAIL to_cur: got %0d expected 1", cur_stage_o); end
    step(5);
    checks++; if (seq_error_o !== 1'b1) begin errors++; $display("FAIL to_err_held: got %b expected 1", seq_error_o); end
    reset_0 = 1'b1;
    step();
    reset_0 = 1'b0;
    checks++; if (seq_error_o !== 1'b0) begin errors++; $display("FAIL to_err_clr: got %b expected 0", seq_error_o); end
`else
    step(1000);
    checks++; if (stage_rst_o !== 3'b100) begin errors++; $display("FAIL nto_rst: got %b expected 100", stage_rst_o); end
    checks++; if (cur_stage_o !== 4'd1) begin errors++; $display("FAIL nto_cur: got %0d expected 1", cur_stage_o); end
    checks++; if (seq_error_o !== 1'b0) begin errors++; $display("FAIL nto_err: got %b expected 0", seq_error_o); end
    checks++; if (seq_done_o !== 1'b0) begin errors++; $display("FAIL nto_done: got %b expected 0", seq_done_o); end
`endif
  endtask

  initial begin
    reset_0 = 1'b1; ext_rst_req = 1'b0; stage_ack_i = 3'b000;
    test_reset();
    test_sequence();
    test_all_acks();
    test_debounce();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
